// File: rtl/nora_bram_loader.sv
// nora_bram_loader: byte-wide block RAM with a NORA slave port and a streaming loader.
// Optional macro NORA_BRAM_LD_CHECKSUM_EN adds the ld_sum_o running checksum output.
module nora_bram_loader #(
    parameter int ADDR_BITS = 9,
    parameter     INIT_FILE = "",
    parameter bit WP_RESET  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] slv_addr_i,
    input  logic [7:0]           slv_datawr_i,
    input  logic                 slv_datawr_valid,
    output logic [7:0]           slv_datard_o,
    input  logic                 slv_req_i,
    input  logic                 slv_rwn_i,
    input  logic                 wp_set_i,
    output logic                 wp_o,
    input  logic                 ld_start_i,
    input  logic [ADDR_BITS-1:0] ld_addr_i,
    input  logic [ADDR_BITS:0]   ld_len_i,
    input  logic [7:0]           ld_data_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    output logic                 ld_busy_o,
    output logic                 ld_done_o
`ifdef NORA_BRAM_LD_CHECKSUM_EN
    ,
    output logic [7:0]           ld_sum_o
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS:0]   cnt;
    logic [7:0]           mem [DEPTH];
    logic                 beat;
    logic                 slv_we;
    logic                 start_ok;

    // The slave owns the single RAM port whenever it is selected.
    assign ld_ready_o = (state == LOAD) & ~slv_req_i;
    // A beat in a reset cycle is discarded so an aborted load writes nothing more.
    assign beat       = ld_valid_i & ld_ready_o & ~reset;
    assign slv_we     = slv_req_i & ~slv_rwn_i & slv_datawr_valid & ~wp_o;
    assign start_ok   = ld_start_i & ~wp_o;

    // Single RAM write port: loader beats and slave writes never coincide.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[addr] <= ld_data_i;
        end else if (slv_we) begin
            mem[slv_addr_i] <= slv_datawr_i;
        end
    end

    // Registered slave read; held while the port is busy with a loader write.
    always_ff @(posedge clk) begin
        if (reset) begin
            slv_datard_o <= 8'h00;
        end else if (!beat) begin
            slv_datard_o <= mem[slv_addr_i];
        end
    end

    // Sticky write-protect latch, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_o <= WP_RESET;
        end else if (wp_set_i) begin
            wp_o <= 1'b1;
        end
    end

    // Loader sequencer with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            ld_busy_o <= 1'b0;
            ld_done_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ld_done_o <= 1'b0;
                    if (start_ok) begin
                        addr <= ld_addr_i;
                        cnt  <= ld_len_i;
                        if (ld_len_i == '0) begin
                            state     <= DONE;
                            ld_done_o <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            ld_busy_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        addr <= addr + ADDR_BITS'(1);
                        cnt  <= cnt - (ADDR_BITS + 1)'(1);
                        if (cnt == (ADDR_BITS + 1)'(1)) begin
                            state     <= DONE;
                            ld_busy_o <= 1'b0;
                            ld_done_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    ld_done_o <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    ld_busy_o <= 1'b0;
                    ld_done_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef NORA_BRAM_LD_CHECKSUM_EN
    // Running 8-bit sum of accepted beats, restarted by each accepted load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_sum_o <= 8'h00;
        end else if (state == IDLE && start_ok) begin
            ld_sum_o <= 8'h00;
        end else if (beat) begin
            ld_sum_o <= ld_sum_o + ld_data_i;
        end
    end
`endif

endmodule

// File: tb/tb_nora_bram_loader.sv
// tb_nora_bram_loader: scoreboard bench with a behavioural RAM/loader model.
// Reads and done pulses are queued by the driver and checked by a monitor.
module tb_nora_bram_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] slv_addr_i = '0;
    logic [7:0] slv_datawr_i = '0;
    logic       slv_datawr_valid = 1'b0;
    logic [7:0] slv_datard_o;
    logic       slv_req_i = 1'b0;
    logic       slv_rwn_i = 1'b1;
    logic       wp_set_i = 1'b0;
    logic       wp_o;
    logic       ld_start_i = 1'b0;
    logic [8:0] ld_addr_i = '0;
    logic [9:0] ld_len_i = '0;
    logic [7:0] ld_data_i = '0;
    logic       ld_valid_i = 1'b0;
    logic       ld_ready_o;
    logic       ld_busy_o;
    logic       ld_done_o;
`ifdef NORA_BRAM_LD_CHECKSUM_EN
    logic [7:0] ld_sum_o;
`endif

    nora_bram_loader #(
        .ADDR_BITS(9),
        .INIT_FILE(""),
        .WP_RESET(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .slv_addr_i(slv_addr_i),
        .slv_datawr_i(slv_datawr_i),
        .slv_datawr_valid(slv_datawr_valid),
        .slv_datard_o(slv_datard_o),
        .slv_req_i(slv_req_i),
        .slv_rwn_i(slv_rwn_i),
        .wp_set_i(wp_set_i),
        .wp_o(wp_o),
        .ld_start_i(ld_start_i),
        .ld_addr_i(ld_addr_i),
        .ld_len_i(ld_len_i),
        .ld_data_i(ld_data_i),
        .ld_valid_i(ld_valid_i),
        .ld_ready_o(ld_ready_o),
        .ld_busy_o(ld_busy_o),
        .ld_done_o(ld_done_o)
`ifdef NORA_BRAM_LD_CHECKSUM_EN
        ,
        .ld_sum_o(ld_sum_o)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ecnt = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int         cyc;
        logic [8:0] a;
        logic [7:0] v;
    } rd_t;

    typedef struct {
        int         cyc;
        logic [7:0] sum;
    } dn_t;

    rd_t rq[$];
    dn_t dq[$];

    // Reference model state.
    logic [7:0] m_mem [512];
    logic       m_wp = 1'b0;
    logic       m_loading = 1'b0;
    logic       m_in_done = 1'b0;
    int         m_addr = 0;
    int         m_rem = 0;
    logic [7:0] m_sum = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, ecnt, act, exp);
        end
    endtask

    // Monitor: compares registered outputs against queued expectations.
    always @(posedge clk) begin
        rd_t  e;
        dn_t  d;
        logic exp_done;
        #3;
        if (rq.size() > 0 && rq[0].cyc == ecnt) begin
            e = rq.pop_front();
            chk($sformatf("slv_rd[%0h]", e.a), {24'h0, slv_datard_o}, {24'h0, e.v});
        end
        exp_done = (dq.size() > 0 && dq[0].cyc == ecnt);
        if (exp_done || ld_done_o) begin
            chk("ld_done", {31'h0, ld_done_o}, {31'h0, exp_done});
            if (exp_done) begin
                d = dq.pop_front();
`ifdef NORA_BRAM_LD_CHECKSUM_EN
                chk("ld_sum", {24'h0, ld_sum_o}, {24'h0, d.sum});
`endif
            end
        end
    end

    task automatic tick(input logic req, input logic rwn, input logic [8:0] a,
                        input logic [7:0] wd, input logic wv, input logic lv,
                        input logic [7:0] ld, input logic st, input logic [8:0] sa,
                        input logic [9:0] sl, input logic wps);
        logic was_done;
        logic bt;
        @(posedge clk);
        #1;
        slv_req_i        = req;
        slv_rwn_i        = rwn;
        slv_addr_i       = a;
        slv_datawr_i     = wd;
        slv_datawr_valid = wv;
        ld_valid_i       = lv;
        ld_data_i        = ld;
        ld_start_i       = st;
        ld_addr_i        = sa;
        ld_len_i         = sl;
        wp_set_i         = wps;
        #1;
        was_done  = m_in_done;
        m_in_done = 1'b0;
        bt = m_loading && lv && !req;
        chk("ld_ready", {31'h0, ld_ready_o}, {31'h0, m_loading && !req});
        chk("ld_busy", {31'h0, ld_busy_o}, {31'h0, m_loading});
        chk("wp", {31'h0, wp_o}, {31'h0, m_wp});
        if (req && rwn) rq.push_back('{ecnt + 1, a, m_mem[a]});
        if (bt) begin
            m_mem[m_addr] = ld;
            m_addr = (m_addr + 1) % 512;
            m_sum  = m_sum + ld;
            m_rem  = m_rem - 1;
            if (m_rem == 0) begin
                m_loading = 1'b0;
                m_in_done = 1'b1;
                dq.push_back('{ecnt + 1, m_sum});
            end
        end else if (!m_loading && !was_done && st && !m_wp) begin
            m_addr = int'(sa);
            m_rem  = int'(sl);
            m_sum  = 8'h00;
            if (sl == 0) begin
                m_in_done = 1'b1;
                dq.push_back('{ecnt + 1, m_sum});
            end else begin
                m_loading = 1'b1;
            end
        end
        if (req && !rwn && wv && !m_wp) m_mem[a] = wd;
        if (wps) m_wp = 1'b1;
    endtask

    task automatic idle();
        tick(0, 1, 9'h0, 8'h0, 0, 0, 8'h0, 0, 9'h0, 10'h0, 0);
    endtask

    task automatic rd(input logic [8:0] a);
        tick(1, 1, a, 8'h0, 0, 0, 8'h0, 0, 9'h0, 10'h0, 0);
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        tick(1, 0, a, d, 1, 0, 8'h0, 0, 9'h0, 10'h0, 0);
    endtask

    task automatic start(input logic [8:0] sa, input logic [9:0] sl);
        tick(0, 1, 9'h0, 8'h0, 0, 0, 8'h0, 1, sa, sl, 0);
    endtask

    task automatic feed(input logic [7:0] d);
        tick(0, 1, 9'h0, 8'h0, 0, 1, d, 0, 9'h0, 10'h0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset            = 1'b1;
        slv_req_i        = 1'b0;
        slv_datawr_valid = 1'b0;
        ld_valid_i       = 1'b0;
        ld_start_i       = 1'b0;
        wp_set_i         = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_datard", {24'h0, slv_datard_o}, 32'h0);
        chk("rst_busy", {31'h0, ld_busy_o}, 32'h0);
        chk("rst_done", {31'h0, ld_done_o}, 32'h0);
        chk("rst_ready", {31'h0, ld_ready_o}, 32'h0);
        chk("rst_wp", {31'h0, wp_o}, 32'h0);
        reset     = 1'b0;
        m_loading = 1'b0;
        m_in_done = 1'b0;
        m_wp      = 1'b0;
        m_sum     = 8'h00;
    endtask

    initial begin
        do_reset();

        // Give every RAM location a known value.
        for (int i = 0; i < 512; i++) wr(9'(i), 8'($urandom));
        idle();

        // Basic 4-byte load at 0x010.
        start(9'h010, 10'd4);
        feed(8'h11);
        feed(8'h22);
        feed(8'h33);
        feed(8'h44);
        idle();
        idle();
        for (int i = 0; i < 4; i++) rd(9'(16 + i));
        idle();

        // Wrap-around load from 0x1FE.
        start(9'h1FE, 10'd4);
        for (int i = 0; i < 4; i++) feed(8'(8'hA0 + i));
        idle();
        idle();
        rd(9'h1FE);
        rd(9'h1FF);
        rd(9'h000);
        rd(9'h001);
        idle();

        // Slave read stalls a 3-byte load for two cycles.
        start(9'h030, 10'd3);
        feed(8'h61);
        tick(1, 1, 9'h000, 8'h0, 0, 1, 8'h62, 0, 9'h0, 10'h0, 0);
        tick(1, 1, 9'h000, 8'h0, 0, 1, 8'h62, 0, 9'h0, 10'h0, 0);
        feed(8'h62);
        feed(8'h63);
        idle();
        rd(9'h030);
        rd(9'h031);
        rd(9'h032);
        idle();

        // Zero-length load.
        start(9'h040, 10'd0);
        idle();
        idle();
        rd(9'h040);
        idle();

        // Checksum load.
        start(9'h050, 10'd3);
        feed(8'hFF);
        feed(8'h02);
        feed(8'h10);
        idle();
        idle();

        // Reset aborts a 5-byte load after two beats.
        start(9'h060, 10'd5);
        feed(8'h71);
        feed(8'h72);
        do_reset();
        idle();
        idle();
        rd(9'h060);
        rd(9'h061);
        rd(9'h062);
        idle();

        // Full-depth load from 0x100.
        start(9'h100, 10'd512);
        for (int i = 0; i < 512; i++) feed(8'($urandom));
        idle();
        idle();
        rd(9'h100);
        rd(9'h1FF);
        rd(9'h000);
        rd(9'h0FF);
        idle();

        // Randomised mix of slave traffic and loads.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom % 10) < 3, $urandom % 2, 9'($urandom), 8'($urandom),
                 ($urandom % 4) != 0, ($urandom % 4) != 0, 8'($urandom),
                 ($urandom % 8) == 0, 9'($urandom), 10'($urandom % 10), 0);
        end
        for (int i = 0; i < 20; i++) feed(8'($urandom));
        idle();
        idle();
        for (int i = 0; i < 40; i++) rd(9'($urandom));
        idle();

        // Write-protect blocks slave writes and new loads.
        wr(9'h020, 8'h5A);
        tick(0, 1, 9'h0, 8'h0, 0, 0, 8'h0, 0, 9'h0, 10'h0, 1);
        wr(9'h020, 8'hC3);
        rd(9'h020);
        start(9'h070, 10'd3);
        idle();
        feed(8'hEE);
        idle();
        rd(9'h020);
        rd(9'h070);
        idle();
        idle();
        do_reset();
        idle();
        idle();

        chk("rd_queue_empty", rq.size(), 32'h0);
        chk("done_queue_empty", dq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
